// File: rtl/pwm_ctrl_pkg.sv
// Shared types and helpers for the PWM ramp controller: default widths,
// the run/idle state encoding and the per-period duty slew function.
package pwm_ctrl_pkg;

  // Default duty / PWM counter width and the matching counter wrap value.
  localparam int unsigned DEF_DUTY_W = 8;
  localparam int unsigned PWM_MAX    = (2 ** DEF_DUTY_W) - 2;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } state_e;

  // Move 'active' toward 'target' by at most 'step'; never overshoots.
  // Arithmetic is done on 32-bit unsigned values, so duty-width operands
  // cannot wrap in either direction.
  function automatic int unsigned ramp_next(input int unsigned active,
                                            input int unsigned target,
                                            input int unsigned step);
    int unsigned diff;
    if (target >= active) begin
      diff = target - active;
      return active + ((diff < step) ? diff : step);
    end else begin
      diff = active - target;
      return active - ((diff < step) ? diff : step);
    end
  endfunction

endpackage

// File: rtl/pwm_prescaler.sv
// Clock-enable generator: asserts tick once every prescale+1 clk cycles.
// While clear is high the count is held at zero and no tick is issued.
module pwm_prescaler #(
  parameter int unsigned PRESCALE_W = 16
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  clear,
  input  logic [PRESCALE_W-1:0] prescale,
  output logic                  tick
);

  logic [PRESCALE_W-1:0] pcnt_q;
  logic [PRESCALE_W-1:0] pcnt_d;
  logic                  at_limit;

  // A >= compare means that lowering prescale below the current count
  // produces a tick on the very next clk instead of running to overflow.
  assign at_limit = (pcnt_q >= prescale);
  assign tick     = !clear && at_limit;

  // Next count: restart on clear or at the limit, otherwise increment.
  always_comb begin
    // NOTE: every branch of a combinational block must assign its outputs;
    // the default here is what keeps this from inferring a latch.
    pcnt_d = pcnt_q + 1'b1;
    if (clear || at_limit) begin
      pcnt_d = '0;
    end
  end

  // Count register with synchronous reset.
  always_ff @(posedge clk) begin
    // NOTE: sequential state is always written with <= so every flop
    // samples the pre-edge value of its inputs, independent of block order.
    if (reset) begin
      pcnt_q <= '0;
    end else begin
      pcnt_q <= pcnt_d;
    end
  end

endmodule

// File: rtl/pwm_ramp_ctrl.sv
// PWM generator with period-boundary duty updates and optional soft-start
// slew. duty_target is only sampled on the clk where the PWM counter wraps,
// so the waveform never shows a partial-period glitch.
module pwm_ramp_ctrl #(
  parameter int unsigned DUTY_W     = pwm_ctrl_pkg::DEF_DUTY_W,
  parameter int unsigned PRESCALE_W = 16,
  parameter int unsigned RAMP_STEP  = 1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  enable,
  input  logic                  ramp_en,
  input  logic [PRESCALE_W-1:0] prescale,
  input  logic [DUTY_W-1:0]     duty_target,
  output logic                  pwm_out,
  output logic [DUTY_W-1:0]     duty_active,
  output logic                  period_start,
  output logic                  ramp_busy
);

  import pwm_ctrl_pkg::*;

  // Last counter value before wrap: 2**DUTY_W-2, so a full period is
  // 2**DUTY_W-1 ticks and a duty of all-ones keeps the output high.
  localparam logic [DUTY_W-1:0] CNT_MAX = {{(DUTY_W-1){1'b1}}, 1'b0};

  state_e            state_q;
  state_e            state_d;
  logic [DUTY_W-1:0] cnt_q;
  logic [DUTY_W-1:0] cnt_d;
  logic [DUTY_W-1:0] duty_q;
  logic [DUTY_W-1:0] duty_d;
  logic              pwm_q;
  logic              pwm_d;
  logic              pstart_q;
  logic              pstart_d;

  logic              run;
  logic              tick;
  logic              wrap;
  logic [DUTY_W-1:0] ramp_val;

  // Counting only happens while running and still enabled; dropping enable
  // clears the prescaler on the same edge that returns the FSM to idle.
  assign run = (state_q == ST_RUN) && enable;

  pwm_prescaler #(
    .PRESCALE_W (PRESCALE_W)
  ) u_prescaler (
    .clk      (clk),
    .reset    (reset),
    .clear    (!run),
    .prescale (prescale),
    .tick     (tick)
  );

  // Candidate duty for a ramped boundary update.
  assign ramp_val = DUTY_W'(ramp_next(32'(duty_q), 32'(duty_target), RAMP_STEP));

  // Next-state logic for the FSM, PWM counter, applied duty and outputs.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    duty_d   = duty_q;
    pwm_d    = 1'b0;
    pstart_d = 1'b0;
    wrap     = 1'b0;

    case (state_q)
      ST_IDLE: begin
        cnt_d  = '0;
        duty_d = '0;
        if (enable) begin
          state_d = ST_RUN;
          // Without ramping the target is applied immediately; with ramping
          // the duty starts from zero and slews up at each boundary.
          duty_d  = ramp_en ? '0 : duty_target;
        end
      end

      ST_RUN: begin
        if (!enable) begin
          // Disable beats a coincident boundary: no pulse, duty forced to 0.
          state_d = ST_IDLE;
          cnt_d   = '0;
          duty_d  = '0;
        end else begin
          // Compare uses the current count and duty; the new duty takes
          // effect together with count 0, so the wrap is glitch-free.
          pwm_d = (cnt_q < duty_q);
          if (tick) begin
            wrap  = (cnt_q == CNT_MAX);
            cnt_d = wrap ? '0 : cnt_q + 1'b1;
          end
          if (wrap) begin
            pstart_d = 1'b1;
            duty_d   = ramp_en ? ramp_val : duty_target;
          end
        end
      end

      default: begin
        state_d = ST_IDLE;
        cnt_d   = '0;
        duty_d  = '0;
      end
    endcase
  end

  // FSM and datapath registers; synchronous reset returns everything to idle.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= ST_IDLE;
      cnt_q    <= '0;
      duty_q   <= '0;
      pwm_q    <= 1'b0;
      pstart_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      duty_q   <= duty_d;
      pwm_q    <= pwm_d;
      pstart_q <= pstart_d;
    end
  end

  assign pwm_out      = pwm_q;
  assign duty_active  = duty_q;
  assign period_start = pstart_q;
  assign ramp_busy    = (state_q == ST_RUN) && (duty_q != duty_target);

endmodule

// File: tb/tb_pwm_ramp_ctrl.sv
// Directed bench for pwm_ramp_ctrl (DUTY_W=8, RAMP_STEP=4). Inputs change
// and outputs are sampled on the falling clock edge.
module tb_pwm_ramp_ctrl;

  logic        clk = 1'b0;
  logic        reset;
  logic        enable;
  logic        ramp_en;
  logic [15:0] prescale;
  logic [7:0]  duty_target;
  logic        pwm_out;
  logic [7:0]  duty_active;
  logic        period_start;
  logic        ramp_busy;

  int n_tests = 0;
  int n_fail  = 0;
  int lat;
  int high;
  int len;

  localparam int BOUND = 5000;

  pwm_ramp_ctrl #(
    .DUTY_W     (8),
    .PRESCALE_W (16),
    .RAMP_STEP  (4)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .enable       (enable),
    .ramp_en      (ramp_en),
    .prescale     (prescale),
    .duty_target  (duty_target),
    .pwm_out      (pwm_out),
    .duty_active  (duty_active),
    .period_start (period_start),
    .ramp_busy    (ramp_busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Step falling edges until period_start is seen; lat = edges stepped.
  task automatic wait_ps(input string tag, output int lat_o);
    bit found = 1'b0;
    lat_o = 0;
    while (!found && lat_o < BOUND) begin
      @(negedge clk);
      lat_o++;
      if (period_start) found = 1'b1;
    end
    check({tag, "_ps_seen"}, 32'(found), 1);
  endtask

  // Starting on a period_start cycle, count pwm_out highs and length up to
  // and including the next period_start. Optionally rewrite duty_target
  // chg_at cycles into the period.
  task automatic measure(input string tag, input int chg_at, input logic [7:0] chg_val,
                         output int high_o, output int len_o);
    bit found = 1'b0;
    high_o = 0;
    len_o  = 0;
    while (!found && len_o < BOUND) begin
      @(negedge clk);
      len_o++;
      high_o += int'(pwm_out);
      if (period_start) found = 1'b1;
      if (len_o == chg_at) duty_target = chg_val;
    end
    check({tag, "_ps_seen"}, 32'(found), 1);
  endtask

  initial begin
    reset       = 1'b1;
    enable      = 1'b0;
    ramp_en     = 1'b0;
    prescale    = 16'd0;
    duty_target = 8'd255;
    repeat (3) @(negedge clk);
    check("rst_pwm", 32'(pwm_out), 0);
    check("rst_duty", 32'(duty_active), 0);
    check("rst_ps", 32'(period_start), 0);
    check("rst_busy", 32'(ramp_busy), 0);
    reset = 1'b0;
    @(negedge clk);

    // 1: prescale 0, duty 128, no ramp.
    duty_target = 8'd128;
    enable      = 1'b1;
    wait_ps("t1", lat);
    check("t1_first_lat", 32'(lat), 256);
    check("t1_duty", 32'(duty_active), 128);
    for (int i = 0; i < 2; i++) begin
      measure("t1", -1, 8'd0, high, len);
      check("t1_high", 32'(high), 128);
      check("t1_len", 32'(len), 255);
    end

    // 2: target 0 mid-period is held off until the boundary, then stays low.
    measure("t2a", 10, 8'd0, high, len);
    check("t2_hold_high", 32'(high), 128);
    check("t2_duty0", 32'(duty_active), 0);
    for (int i = 0; i < 3; i++) begin
      measure("t2b", -1, 8'd0, high, len);
      check("t2_zero_high", 32'(high), 0);
    end
    duty_target = 8'd255;
    measure("t2c", -1, 8'd0, high, len);
    check("t2_trans_high", 32'(high), 0);
    check("t2_duty255", 32'(duty_active), 255);
    for (int i = 0; i < 3; i++) begin
      measure("t2d", -1, 8'd0, high, len);
      check("t2_full_high", 32'(high), 255);
      check("t2_full_len", 32'(len), 255);
    end

    // 4: duty 200, target 50 written mid-period applies next period.
    duty_target = 8'd200;
    measure("t4a", -1, 8'd0, high, len);
    check("t4_duty200", 32'(duty_active), 200);
    measure("t4b", 100, 8'd50, high, len);
    check("t4_cur_high", 32'(high), 200);
    check("t4_duty50", 32'(duty_active), 50);
    measure("t4c", -1, 8'd0, high, len);
    check("t4_next_high", 32'(high), 50);

    // 5: disable mid-period, then reset mid-period, then disable on a boundary.
    repeat (20) @(negedge clk);
    check("t5_pwm_before", 32'(pwm_out), 1);
    enable = 1'b0;
    @(negedge clk);
    check("t5_dis_pwm", 32'(pwm_out), 0);
    check("t5_dis_duty", 32'(duty_active), 0);
    check("t5_dis_busy", 32'(ramp_busy), 0);
    @(negedge clk);
    enable = 1'b1;
    wait_ps("t5a", lat);
    check("t5_restart_lat", 32'(lat), 256);
    repeat (30) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    check("t5_rst_pwm", 32'(pwm_out), 0);
    check("t5_rst_duty", 32'(duty_active), 0);
    check("t5_rst_ps", 32'(period_start), 0);
    reset = 1'b0;
    wait_ps("t5b", lat);
    check("t5_rst_lat", 32'(lat), 256);
    check("t5_rst_duty_back", 32'(duty_active), 50);
    repeat (254) @(negedge clk);
    check("t5_pre_wrap_ps", 32'(period_start), 0);
    enable = 1'b0;
    @(negedge clk);
    check("t5_wrap_dis_ps", 32'(period_start), 0);
    check("t5_wrap_dis_duty", 32'(duty_active), 0);

    // 3: ramp step 4 from idle toward 10, then down to 3, then jump.
    @(negedge clk);
    ramp_en     = 1'b1;
    duty_target = 8'd10;
    enable      = 1'b1;
    @(negedge clk);
    check("t3_start_duty", 32'(duty_active), 0);
    check("t3_start_busy", 32'(ramp_busy), 1);
    wait_ps("t3a", lat);
    check("t3_duty4", 32'(duty_active), 4);
    check("t3_busy4", 32'(ramp_busy), 1);
    measure("t3b", -1, 8'd0, high, len);
    check("t3_high4", 32'(high), 4);
    check("t3_duty8", 32'(duty_active), 8);
    measure("t3c", -1, 8'd0, high, len);
    check("t3_duty10", 32'(duty_active), 10);
    check("t3_busy10", 32'(ramp_busy), 0);
    duty_target = 8'd3;
    measure("t3d", -1, 8'd0, high, len);
    check("t3_high10", 32'(high), 10);
    check("t3_duty6", 32'(duty_active), 6);
    measure("t3e", -1, 8'd0, high, len);
    check("t3_duty3", 32'(duty_active), 3);
    check("t3_busy3", 32'(ramp_busy), 0);
    ramp_en     = 1'b0;
    duty_target = 8'd100;
    measure("t3f", -1, 8'd0, high, len);
    check("t3_jump100", 32'(duty_active), 100);

    // 6: prescale 3 -> 4 clk per tick, 1020 clk period, 512 clk high.
    enable = 1'b0;
    @(negedge clk);
    prescale    = 16'd3;
    duty_target = 8'd128;
    enable      = 1'b1;
    wait_ps("t6", lat);
    check("t6_first_lat", 32'(lat), 1021);
    measure("t6", -1, 8'd0, high, len);
    check("t6_len", 32'(len), 1020);
    check("t6_high", 32'(high), 512);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
